jk_reg_bank: RTL and testbench

- Parametrised successor to the team's single-bit JK flip-flop: a WIDTH-bit bank of independent per-bit flip-flops.
- Runtime mode select makes the bank behave as JK, D, T or SR storage.
- Adds features the single-bit cell lacks: asynchronous active-low reset, clock enable, parallel load, per-bit change detection, and SR illegal-input error flags (per-cycle and sticky).
- Used as a general-purpose control/status register element in the sequential-logic library.

---
 rtl/jk_reg_bank.sv | 78 +++++++
 tb/tb_jk_reg_bank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of independent flip-flops with runtime JK/D/T/SR mode,
// parallel load, clock enable, per-bit change detection and SR error flags.
module jk_reg_bank #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] changed,
   output logic [WIDTH-1:0] sr_err,
   output logic             sr_err_sticky
);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] err_next;

   // k is only looked at in JK and SR modes so an undriven k cannot leak into D/T.
   always_comb begin
      q_next   = q;
      err_next = '0;
      if (load) begin
         q_next = load_data;
      end else if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            case (mode)
               2'b00: begin
                  case ({j[i], k[i]})
                     2'b01:   q_next[i] = 1'b0;
                     2'b10:   q_next[i] = 1'b1;
                     2'b11:   q_next[i] = ~q[i];
                     default: q_next[i] = q[i];
                  endcase
               end
               2'b01: q_next[i] = j[i];
               2'b10: q_next[i] = q[i] ^ j[i];
               default: begin
                  case ({j[i], k[i]})
                     2'b01:   q_next[i] = 1'b0;
                     2'b10:   q_next[i] = 1'b1;
                     2'b11:   err_next[i] = 1'b1;
                     default: q_next[i] = q[i];
                  endcase
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q             <= RESET_VAL;
         changed       <= '0;
         sr_err        <= '0;
         sr_err_sticky <= 1'b0;
      end else begin
         q       <= q_next;
         changed <= q_next ^ q;
         sr_err  <= err_next;
         // A fresh error on the clearing edge wins over the clear.
         if (err_clr)
            sr_err_sticky <= |err_next;
         else
            sr_err_sticky <= sr_err_sticky | (|err_next);
      end
   end

   assign qn = ~q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: word-level reference model compared
// every cycle, plus directed steps with hand-computed literal expectations.
module tb_jk_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] j = '0;
   logic [7:0] k = '0;
   logic       load = 1'b0;
   logic [7:0] load_data = '0;
   logic       err_clr = 1'b0;
   logic [7:0] q, qn, changed, sr_err;
   logic       sr_err_sticky;

   int checks = 0;
   int errors = 0;

   jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k),
      .load(load), .load_data(load_data), .err_clr(err_clr),
      .q(q), .qn(qn), .changed(changed), .sr_err(sr_err),
      .sr_err_sticky(sr_err_sticky)
   );

   always #5 clk = ~clk;

   // Reference model: whole-word boolean equations for each storage mode.
   logic [7:0] m_q, m_ch, m_err, nq, old, nerr;
   logic       m_st;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = 8'hA5; m_ch = '0; m_err = '0; m_st = 1'b0;
      end else begin
         old  = m_q;
         nerr = '0;
         if (load)     nq = load_data;
         else if (!en) nq = old;
         else begin
            case (mode)
               2'b00:   nq = (j & ~old) | (~k & old);
               2'b01:   nq = j;
               2'b10:   nq = old ^ j;
               default: begin
                  nq   = (j & ~k) | (old & ~(j ^ k));
                  nerr = j & k;
               end
            endcase
         end
         m_ch  = nq ^ old;
         m_q   = nq;
         m_err = nerr;
         m_st  = err_clr ? (nerr != 0) : (m_st || (nerr != 0));
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_q", q, m_q);
      chk("model_qn", qn, ~m_q);
      chk("model_changed", changed, m_ch);
      chk("model_sr_err", sr_err, m_err);
      chk("model_sticky", {7'b0, sr_err_sticky}, {7'b0, m_st});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic [7:0] ld, input logic e,
                        input logic [1:0] m, input logic [7:0] jj,
                        input logic [7:0] kk, input logic ec);
      load = l; load_data = ld; en = e; mode = m; j = jj; k = kk; err_clr = ec;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_q", q, 8'hA5);

      // Load 3C, then pulse reset mid-cycle
      drive(1, 8'h3C, 0, 2'b00, 8'h00, 8'h00, 0);
      step();
      chk("load_3c", q, 8'h3C);
      drive(0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_q", q, 8'hA5);
      chk("async_rst_qn", qn, 8'h5A);
      chk("async_rst_changed", changed, 8'h00);
      chk("async_rst_sr_err", sr_err, 8'h00);
      chk("async_rst_sticky", {7'b0, sr_err_sticky}, 8'h00);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // JK truth table from q=0F
      drive(1, 8'h0F, 0, 2'b00, 8'h00, 8'h00, 0);
      step();
      drive(0, 8'h00, 1, 2'b00, 8'hCC, 8'hAA, 0);
      step();
      chk("jk_q", q, 8'hC5);
      chk("jk_changed", changed, 8'hCA);

      // D then T, with k left undriven
      drive(1, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
      step();
      drive(0, 8'h00, 1, 2'b01, 8'h5A, 8'hxx, 0);
      step();
      chk("d_q", q, 8'h5A);
      drive(0, 8'h00, 1, 2'b10, 8'hFF, 8'hxx, 0);
      step();
      chk("t1_q", q, 8'hA5);
      chk("t1_changed", changed, 8'hFF);
      step();
      chk("t2_q", q, 8'h5A);
      chk("t2_changed", changed, 8'hFF);

      // SR with one illegal bit
      drive(1, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
      step();
      drive(0, 8'h00, 1, 2'b11, 8'h81, 8'h01, 0);
      step();
      chk("sr_q", q, 8'h80);
      chk("sr_err", sr_err, 8'h01);
      chk("sr_sticky_set", {7'b0, sr_err_sticky}, 8'h01);
      drive(0, 8'h00, 1, 2'b11, 8'h00, 8'h00, 0);
      step();
      chk("sr_err_clear", sr_err, 8'h00);
      chk("sr_sticky_hold", {7'b0, sr_err_sticky}, 8'h01);
      drive(0, 8'h00, 1, 2'b11, 8'h00, 8'h00, 1);
      step();
      chk("sr_sticky_clr", {7'b0, sr_err_sticky}, 8'h00);

      // Enable low holds
      drive(0, 8'h00, 0, 2'b00, 8'hFF, 8'hFF, 0);
      step();
      chk("en0_q", q, 8'h80);
      chk("en0_changed", changed, 8'h00);

      // Load beats an illegal SR pattern
      drive(1, 8'h33, 1, 2'b11, 8'hFF, 8'hFF, 0);
      step();
      chk("load_prio_q", q, 8'h33);
      chk("load_prio_sr_err", sr_err, 8'h00);
      chk("load_prio_changed", changed, 8'hB3);

      // New error and clear on the same edge
      drive(0, 8'h00, 1, 2'b11, 8'h02, 8'h02, 1);
      step();
      chk("collide_sticky", {7'b0, sr_err_sticky}, 8'h01);
      chk("collide_sr_err", sr_err, 8'h02);
      chk("collide_q", q, 8'h33);

      // Mixed traffic checked by the model alone
      for (int n = 0; n < 60; n++) begin
         drive(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 5) == 0));
         step();
      end

      drive(0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
